// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Target/duty bus between a duty source and the ramp scheduler.
//   en        run enable
//   tgt_duty  requested target duty (W bits)
//   tgt_vld   target valid
//   tgt_rdy   target can be accepted this cycle
//   duty      duty to the PWM generator (W bits)
//   prd_strt  first cycle of a PWM period
//   ramping   scheduler is slewing toward the target
//   done      one-cycle pulse when duty reaches the target
// master: the side that supplies targets; slave: the scheduler.
interface pwm_duty_ramp_ctrl_if #(
    parameter int unsigned W = 11
);
    logic         en;
    logic [W-1:0] tgt_duty;
    logic         tgt_vld;
    logic         tgt_rdy;
    logic [W-1:0] duty;
    logic         prd_strt;
    logic         ramping;
    logic         done;

    modport master (
        output en, tgt_duty, tgt_vld,
        input  tgt_rdy, duty, prd_strt, ramping, done
    );

    modport slave (
        input  en, tgt_duty, tgt_vld,
        output tgt_rdy, duty, prd_strt, ramping, done
    );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start / duty-ramp scheduler for the PWM generator.
// Accepts a target duty over valid/ready and slews the registered duty toward
// it by STEP once per PWM period (2^W clk cycles), updating only at period
// boundaries. A free-running period counter mirrors the PWM counter.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  pwm_duty_ramp_ctrl_if.slave (en, tgt_duty/tgt_vld/tgt_rdy,
//        duty, prd_strt, ramping, done)
// Optional feature: define PWM_DUTY_CLAMP_EN to clamp accepted targets to
// MAX_DUTY; otherwise MAX_DUTY has no effect.
module pwm_duty_ramp_ctrl #(
    parameter int unsigned  W        = 11,
    parameter int unsigned  STEP     = 8,
    parameter logic [W-1:0] MAX_DUTY = W'(11'h7C0)
) (
    input logic                 clk,
    input logic                 rst,
    pwm_duty_ramp_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [W-1:0] CNT_LAST = {W{1'b1}};
    localparam logic [W-1:0] STEP_W   = W'(STEP);
    localparam logic [W:0]   STEP_X   = (W+1)'(STEP);

`ifdef PWM_DUTY_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic         done_q, done_d;
    logic         ramping_q, ramping_d;
    logic         tgt_rdy_q, tgt_rdy_d;

    logic         bnd_c;
    logic         xfer_c;
    logic [W-1:0] tgt_in_c;
    logic [W:0]   diff_c;

    // Accepted target, optionally limited to the duty ceiling.
    assign tgt_in_c = (CLAMP_EN && (bus.tgt_duty > MAX_DUTY)) ? MAX_DUTY : bus.tgt_duty;

    assign bnd_c  = bus.en & (cnt_q == CNT_LAST);
    assign xfer_c = bus.tgt_vld & tgt_rdy_q;

    // Distance to target at W+1 bits so any STEP compares without wrap.
    assign diff_c = (tgt_q >= duty_q) ? ({1'b0, tgt_q} - {1'b0, duty_q})
                                      : ({1'b0, duty_q} - {1'b0, tgt_q});

    // Next-state and output decode.
    always_comb begin
        cnt_d   = bus.en ? (cnt_q + W'(1)) : cnt_q;
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (xfer_c) begin
                    tgt_d = tgt_in_c;
                    if (tgt_in_c == duty_q) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (bnd_c) begin
                    if (diff_c <= STEP_X) begin
                        duty_d  = tgt_q;
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end else if (tgt_q > duty_q) begin
                        duty_d = duty_q + STEP_W;
                    end else begin
                        duty_d = duty_q - STEP_W;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ramping_d = (state_d == RAMP);
        tgt_rdy_d = (state_d != RAMP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            duty_q    <= '0;
            tgt_q     <= '0;
            done_q    <= 1'b0;
            ramping_q <= 1'b0;
            tgt_rdy_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            tgt_q     <= tgt_d;
            done_q    <= done_d;
            ramping_q <= ramping_d;
            tgt_rdy_q <= tgt_rdy_d;
        end
    end

    // Period-start strobe follows en directly; held low while in reset.
    assign bus.prd_strt = bus.en & (cnt_q == '0) & ~rst;
    assign bus.duty     = duty_q;
    assign bus.tgt_rdy  = tgt_rdy_q;
    assign bus.ramping  = ramping_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Bench for pwm_duty_ramp_ctrl: a full-width instance (W=11, STEP=8) for
// directed ramp sequences, and a narrow instance (W=4, STEP=5) for randomized
// traffic against a cycle-level behavioural model and the top-of-range ramp.
module tb_pwm_duty_ramp_ctrl;

    localparam int unsigned  MW    = 11;
    localparam int unsigned  MSTEP = 8;
    localparam int unsigned  SW    = 4;
    localparam int unsigned  SSTEP = 5;
    localparam logic [SW-1:0] SMAX = 4'hC;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    pwm_duty_ramp_ctrl_if #(.W(MW)) m_if ();
    pwm_duty_ramp_ctrl_if #(.W(SW)) s_if ();

    pwm_duty_ramp_ctrl #(.W(MW), .STEP(MSTEP)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    pwm_duty_ramp_ctrl #(.W(SW), .STEP(SSTEP), .MAX_DUTY(SMAX)) u_small (
        .clk (clk),
        .rst (rst_s),
        .bus (s_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Move cur toward tgt by at most step, landing exactly on tgt.
    function automatic int step_toward(input int cur, input int tgt, input int step);
        if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
        return (cur - tgt <= step) ? tgt : cur - step;
    endfunction

    function automatic int clamp_s(input int t);
`ifdef PWM_DUTY_CLAMP_EN
        return (t > int'(SMAX)) ? int'(SMAX) : t;
`else
        return t;
`endif
    endfunction

    // Advance to the next negedge where the main prd_strt is high.
    task automatic wait_prd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_if.prd_strt && n < 8000);
        if (!m_if.prd_strt) chk("prd_timeout", 0, 1);
    endtask

    // Present a target for one cycle; returns at the following negedge.
    task automatic send_main(input logic [MW-1:0] t);
        m_if.tgt_duty = t;
        m_if.tgt_vld  = 1'b1;
        @(negedge clk);
        m_if.tgt_vld  = 1'b0;
    endtask

    typedef struct {
        logic [MW-1:0] tgt;
        int            nper;
        logic [MW-1:0] exp_first;
        logic [MW-1:0] exp_last;
        bit            poke;
    } vec_t;

    vec_t vecs [5];

    int n;
    int p;
    int m_duty;
    int s_cnt, s_duty, s_tgt;
    bit s_ramp, s_done, nd;
    bit en_i, vld_i;
    int t;
    int prev;
    bit wrapped, done_seen;
    int s_top;

    initial begin
        vecs[0] = '{tgt: 11'd40, nper: 5, exp_first: 11'd8,  exp_last: 11'd40, poke: 1'b0};
        vecs[1] = '{tgt: 11'd3,  nper: 5, exp_first: 11'd32, exp_last: 11'd3,  poke: 1'b1};
        vecs[2] = '{tgt: 11'd3,  nper: 0, exp_first: 11'd3,  exp_last: 11'd3,  poke: 1'b0};
        vecs[3] = '{tgt: 11'd40, nper: 5, exp_first: 11'd11, exp_last: 11'd40, poke: 1'b0};
        vecs[4] = '{tgt: 11'd40, nper: 0, exp_first: 11'd40, exp_last: 11'd40, poke: 1'b0};

        rst   = 1'b1;
        rst_s = 1'b1;
        m_if.en = 1'b1; m_if.tgt_vld = 1'b0; m_if.tgt_duty = '0;
        s_if.en = 1'b1; s_if.tgt_vld = 1'b0; s_if.tgt_duty = '0;

        // Reset values, with en already high.
        repeat (3) @(negedge clk);
        chk("rst_duty",     int'(m_if.duty),     0);
        chk("rst_rdy",      int'(m_if.tgt_rdy),  1);
        chk("rst_ramping",  int'(m_if.ramping),  0);
        chk("rst_done",     int'(m_if.done),     0);
        chk("rst_prd_strt", int'(m_if.prd_strt), 0);
        chk("rst_s_prd",    int'(s_if.prd_strt), 0);

        // Idle with no target: duty stays 0, strobe every 2048 cycles.
        rst = 1'b0;
        #1;
        chk("idle_prd_first", int'(m_if.prd_strt), 1);
        repeat (2) begin
            wait_prd(n);
            chk("idle_period_len", n, 2048);
            chk("idle_duty", int'(m_if.duty), 0);
            chk("idle_rdy", int'(m_if.tgt_rdy), 1);
        end

        // Table-driven ramps and immediate-hold transfers.
        m_duty = 0;
        for (int i = 0; i < 5; i++) begin
            send_main(vecs[i].tgt);
            if (vecs[i].nper == 0) begin
                chk("imm_done",    int'(m_if.done),    1);
                chk("imm_ramping", int'(m_if.ramping), 0);
                chk("imm_duty",    int'(m_if.duty),    int'(vecs[i].exp_last));
                @(negedge clk);
                chk("imm_done_clr", int'(m_if.done), 0);
            end else begin
                chk("ramp_start_ramping", int'(m_if.ramping), 1);
                chk("ramp_start_rdy",     int'(m_if.tgt_rdy), 0);
                chk("ramp_start_duty",    int'(m_if.duty),    m_duty);
                p = 0;
                do begin
                    wait_prd(n);
                    p++;
                    m_duty = step_toward(m_duty, int'(vecs[i].tgt), int'(MSTEP));
                    if (p == 1) chk("ramp_first", int'(m_if.duty), int'(vecs[i].exp_first));
                    chk("ramp_step", int'(m_if.duty), m_duty);
                    chk("ramp_done", int'(m_if.done), int'(m_duty == int'(vecs[i].tgt)));
                    if (vecs[i].poke && p == 1) begin
                        m_if.tgt_duty = 11'd500;
                        m_if.tgt_vld  = 1'b1;
                        chk("poke_rdy", int'(m_if.tgt_rdy), 0);
                        @(negedge clk);
                        m_if.tgt_vld  = 1'b0;
                    end
                end while (m_duty != int'(vecs[i].tgt) && p < 10);
                chk("ramp_periods", p, vecs[i].nper);
                chk("ramp_last", int'(m_if.duty), int'(vecs[i].exp_last));
                @(negedge clk);
                chk("ramp_end_done",    int'(m_if.done),    0);
                chk("ramp_end_ramping", int'(m_if.ramping), 0);
                chk("ramp_end_rdy",     int'(m_if.tgt_rdy), 1);
            end
        end

        // Transfer in the boundary cycle: no step at that boundary.
        wait_prd(n);
        repeat (2047) @(negedge clk);
        send_main(11'd16);
        chk("bnd_xfer_prd",     int'(m_if.prd_strt), 1);
        chk("bnd_xfer_duty",    int'(m_if.duty),     40);
        chk("bnd_xfer_ramping", int'(m_if.ramping),  1);
        wait_prd(n);
        chk("bnd_xfer_len",  n, 2048);
        chk("bnd_xfer_step", int'(m_if.duty), 32);

        // en low mid-ramp freezes everything; resumes from the frozen count.
        repeat (100) @(negedge clk);
        m_if.en = 1'b0;
        repeat (5000) @(negedge clk);
        chk("frz_duty",    int'(m_if.duty),     32);
        chk("frz_ramping", int'(m_if.ramping),  1);
        chk("frz_rdy",     int'(m_if.tgt_rdy),  0);
        chk("frz_prd",     int'(m_if.prd_strt), 0);
        m_if.en = 1'b1;
        wait_prd(n);
        chk("frz_resume_len",  n, 1948);
        chk("frz_resume_duty", int'(m_if.duty), 24);

        // Asynchronous reset mid-ramp.
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_duty",    int'(m_if.duty),    0);
        chk("arst_ramping", int'(m_if.ramping), 0);
        chk("arst_rdy",     int'(m_if.tgt_rdy), 1);
        chk("arst_done",    int'(m_if.done),    0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic on the narrow instance against the model.
        @(negedge clk);
        rst_s  = 1'b0;
        s_cnt  = 0; s_duty = 0; s_tgt = 0; s_ramp = 1'b0; s_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            chk("rnd_duty",    int'(s_if.duty),    s_duty);
            chk("rnd_ramping", int'(s_if.ramping), int'(s_ramp));
            chk("rnd_rdy",     int'(s_if.tgt_rdy), int'(!s_ramp));
            chk("rnd_done",    int'(s_if.done),    int'(s_done));
            en_i  = ($urandom_range(0, 9) != 0);
            vld_i = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 3))
                0:       t = 0;
                1:       t = 15;
                2:       t = s_duty;
                default: t = int'($urandom_range(0, 15));
            endcase
            s_if.en       = en_i;
            s_if.tgt_vld  = vld_i;
            s_if.tgt_duty = SW'(t);
            #1;
            chk("rnd_prd_strt", int'(s_if.prd_strt), int'(en_i && s_cnt == 0));
            nd = 1'b0;
            if (s_ramp) begin
                if (en_i && s_cnt == 15) begin
                    s_duty = step_toward(s_duty, s_tgt, int'(SSTEP));
                    if (s_duty == s_tgt) begin
                        s_ramp = 1'b0;
                        nd     = 1'b1;
                    end
                end
            end else if (vld_i) begin
                s_tgt = clamp_s(t);
                if (s_tgt == s_duty) nd = 1'b1;
                else                 s_ramp = 1'b1;
            end
            if (en_i) s_cnt = (s_cnt + 1) % 16;
            s_done = nd;
            @(negedge clk);
        end

        // Ramp to full scale: ends at the ceiling, never wraps.
`ifdef PWM_DUTY_CLAMP_EN
        s_top = int'(SMAX);
`else
        s_top = 15;
`endif
        s_if.tgt_vld = 1'b0;
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        s_if.en       = 1'b1;
        s_if.tgt_duty = 4'hF;
        s_if.tgt_vld  = 1'b1;
        @(negedge clk);
        s_if.tgt_vld  = 1'b0;
        chk("top_ramping", int'(s_if.ramping), 1);
        prev = 0; wrapped = 1'b0; done_seen = 1'b0;
        for (int k = 0; k < 200 && !done_seen; k++) begin
            @(negedge clk);
            if (int'(s_if.duty) < prev) wrapped = 1'b1;
            prev = int'(s_if.duty);
            if (s_if.done) done_seen = 1'b1;
        end
        chk("top_done_seen", int'(done_seen), 1);
        chk("top_final",     int'(s_if.duty), s_top);
        chk("top_no_wrap",   int'(wrapped),   0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
Soft-start / duty-ramp scheduler that drives the 11-bit duty input of the team's PWM generator. It accepts a target duty over a valid/ready handshake and slews the output duty toward that target by STEP per PWM period. Duty changes only at period boundaries, so the PWM never sees a mid-period duty change. It runs a free-running period counter that mirrors the PWM counter and exports a period-start strobe for alignment.

Parameters:
W, 11, duty and period-counter width; period = 2^W clk cycles
STEP, 8, duty increment/decrement applied per period while ramping; range 1..2^W-1
MAX_DUTY, 11'h7C0, duty ceiling; used only when PWM_DUTY_CLAMP_EN is defined

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; low freezes counter, duty and state
tgt_duty  in  W  requested target duty
tgt_vld  in  1  target valid
tgt_rdy  out  1  target can be accepted this cycle
duty  out  W  registered duty to the PWM
prd_strt  out  1  high while cnt==0 and en; first cycle of a PWM period
ramping  out  1  high in RAMP state
done  out  1  one-cycle pulse when duty reaches the target

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: cnt=0, duty=0, tgt_q=0, state=IDLE, done=0, ramping=0, tgt_rdy=1, prd_strt=0 while rst is high.
- Period counter: W-bit cnt increments by 1 each clk when en=1 and wraps 2^W-1 -> 0. It holds when en=0.
- Boundary: bnd = en & (cnt==2^W-1). Duty updates are registered on bnd, so the new duty is valid from the cycle where cnt==0 for a full period.
- Handshake: transfer occurs when tgt_vld & tgt_rdy. tgt_rdy = (state!=RAMP). tgt_duty is sampled into tgt_q on the transfer cycle. tgt_vld while tgt_rdy=0 is ignored; the source must hold it.
- States:
  - IDLE: on transfer, go to HOLD with done=1 next cycle if tgt_q==duty; otherwise go to RAMP.
  - RAMP: on bnd, with diff = |tgt_q - duty| computed at W+1 bits:
    - if diff<=STEP: duty<=tgt_q, go to HOLD, done pulses 1 cycle.
    - else if tgt_q>duty: duty<=duty+STEP.
    - else: duty<=duty-STEP.
  - HOLD: duty is constant. On transfer, same decision as IDLE.
- No overshoot and no wrap: duty never passes tgt_q and never leaves 0..2^W-1, for any STEP.
- Transfer and bnd in the same cycle (IDLE/HOLD): the transfer is taken, and ramping starts at the next bnd. Duty does not change at this bnd.
- en low during RAMP: no abort. State, duty and cnt freeze, and ramping stays 1. Resumes on en high.
- rst asserted mid-ramp: immediately returns all reset values; the PWM sees duty 0.
- done is never asserted together with a duty step except in the final step cycle.

Optional Feature:
PWM_DUTY_CLAMP_EN
- Defined: tgt_q = min(tgt_duty, MAX_DUTY) at transfer, so duty never exceeds MAX_DUTY. The IDLE/HOLD equality check uses the clamped value.
- Undefined: tgt_q = tgt_duty and MAX_DUTY is unused.

Test Plan:
- Reset, then en=1 with no target -> duty stays 0, tgt_rdy=1, prd_strt pulses every 2048 cycles (first at cnt==0 after en rises).
- From duty 0, transfer tgt=40 with STEP=8 -> duty 8,16,24,32,40 at 5 successive period starts; done pulses once on the 40 step; ramping=0 and tgt_rdy=1 after.
- In HOLD at 40, send tgt=3 -> duty 32,24,16,8,3 (final partial step, no underflow); tgt_vld pulse during RAMP is ignored (tgt_rdy=0).
- In HOLD at 40, send tgt=40 -> done pulses next cycle, no ramp, duty unchanged.
- Mid-ramp, drop en for 5000 cycles -> cnt and duty frozen, ramping=1. Re-raise en -> ramp continues from the frozen value. Then assert rst mid-ramp -> duty=0 and state IDLE in the same cycle.
- With PWM_DUTY_CLAMP_EN, send tgt=11'h7FF -> ramp ends at 11'h7C0 with done. Without the macro -> ramp ends at 11'h7FF with no wrap.
